// File: rtl/status_unit.sv
// Processor status (P) register, branch evaluation and NMI/IRQ poll unit for the 6502 core.
// Define STATUS_IRQ_DELAY_EN to qualify IRQs with the previous I flag (one-instruction CLI/SEI/PLP delay).
module status_unit #(
  parameter logic [7:0] P_RESET = 8'h24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] alu_status,
  input  logic       alu_wr,
  input  logic [7:0] plp_data,
  input  logic       plp_wr,
  output logic [7:0] status,
  input  logic       push_brk,
  output logic [7:0] push_data,
  input  logic [2:0] br_cond,
  output logic       br_taken,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       poll,
  output logic       int_pending,
  output logic       int_nmi,
  input  logic       int_ack
);

  localparam int FLAG_N = 7;
  localparam int FLAG_V = 6;
  localparam int FLAG_B = 4;
  localparam int FLAG_I = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       int_nmi_next;
  logic [7:0] p_reg;
  logic [7:0] p_next;
  logic       nmi_q;
  logic       nmi_edge;
  logic       nmi_latch;
  logic       irq_q;
  logic       irq_mask;
  logic       br_flag;

  // A pulled byte never changes the stored B or bit5; the ALU path writes every bit.
  always_comb begin
    p_next = p_reg;
    if (plp_wr) begin
      p_next = {plp_data[7:6], p_reg[5], p_reg[FLAG_B], plp_data[3:0]};
    end else if (alu_wr) begin
      p_next = alu_status;
    end
    if (int_ack) begin
      p_next[FLAG_I] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_reg <= P_RESET;
    end else begin
      p_reg <= p_next;
    end
  end

  assign status    = p_reg | 8'h20;
  assign push_data = {status[7:6], 1'b1, push_brk, status[3:0]};

  always_comb begin
    br_flag = 1'b0;
    case (br_cond[2:1])
      2'b00:   br_flag = p_reg[FLAG_N];
      2'b01:   br_flag = p_reg[FLAG_V];
      2'b10:   br_flag = p_reg[FLAG_C];
      default: br_flag = p_reg[FLAG_Z];
    endcase
  end

  assign br_taken = (br_flag == br_cond[0]);

`ifdef STATUS_IRQ_DELAY_EN
  logic i_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_prev <= 1'b1;
    end else begin
      i_prev <= p_reg[FLAG_I];
    end
  end

  assign irq_mask = i_prev;
`else
  assign irq_mask = p_reg[FLAG_I];
`endif

  assign nmi_edge = nmi_q & ~nmi_n;

  // A fresh NMI edge coinciding with the acknowledge of the previous NMI must not be lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nmi_q     <= 1'b1;
      nmi_latch <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      nmi_q <= nmi_n;
      irq_q <= ~irq_n;
      if (nmi_edge) begin
        nmi_latch <= 1'b1;
      end else if (int_ack && int_nmi) begin
        nmi_latch <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      int_nmi <= 1'b0;
    end else begin
      state   <= state_next;
      int_nmi <= int_nmi_next;
    end
  end

  // Once pending, the sequencer is committed: polls are ignored and the source is frozen.
  always_comb begin
    state_next   = state;
    int_nmi_next = int_nmi;
    case (state)
      IDLE: begin
        if (poll) begin
          if (nmi_latch) begin
            state_next   = PEND;
            int_nmi_next = 1'b1;
          end else if (irq_q && !irq_mask) begin
            state_next   = PEND;
            int_nmi_next = 1'b0;
          end
        end
      end
      PEND: begin
        if (int_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign int_pending = (state == PEND);

endmodule

// File: tb/tb_status_unit.sv
// Directed self-checking bench for status_unit; expectations follow STATUS_IRQ_DELAY_EN when defined.
module tb_status_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] alu_status;
  logic       alu_wr;
  logic [7:0] plp_data;
  logic       plp_wr;
  logic [7:0] status;
  logic       push_brk;
  logic [7:0] push_data;
  logic [2:0] br_cond;
  logic       br_taken;
  logic       nmi_n;
  logic       irq_n;
  logic       poll;
  logic       int_pending;
  logic       int_nmi;
  logic       int_ack;

  int check_count = 0;
  int error_count = 0;

`ifdef STATUS_IRQ_DELAY_EN
  localparam logic DELAY_EN = 1'b1;
`else
  localparam logic DELAY_EN = 1'b0;
`endif

  status_unit #(.P_RESET(8'h24)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_status  (alu_status),
    .alu_wr      (alu_wr),
    .plp_data    (plp_data),
    .plp_wr      (plp_wr),
    .status      (status),
    .push_brk    (push_brk),
    .push_data   (push_data),
    .br_cond     (br_cond),
    .br_taken    (br_taken),
    .nmi_n       (nmi_n),
    .irq_n       (irq_n),
    .poll        (poll),
    .int_pending (int_pending),
    .int_nmi     (int_nmi),
    .int_ack     (int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 8'h%02h, expected 8'h%02h", tag, actual, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    alu_status = 8'h00;
    alu_wr     = 1'b0;
    plp_data   = 8'h00;
    plp_wr     = 1'b0;
    push_brk   = 1'b0;
    br_cond    = 3'b001;
    nmi_n      = 1'b1;
    irq_n      = 1'b1;
    poll       = 1'b0;
    int_ack    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("reset_status", status, 8'h24);
    checkOutput("reset_pending", {7'b0, int_pending}, 8'h00);
    checkOutput("reset_int_nmi", {7'b0, int_nmi}, 8'h00);
    checkOutput("reset_br_taken", {7'b0, br_taken}, 8'h00);
    checkOutput("reset_push_data", push_data, 8'h24);

    // plp beats alu in the same cycle; B kept, bit5 forced
    alu_wr = 1'b1; alu_status = 8'h83;
    plp_wr = 1'b1; plp_data = 8'hFF;
    tick();
    alu_wr = 1'b0; plp_wr = 1'b0;
    checkOutput("plp_over_alu", status, 8'hEF);
    push_brk = 1'b1; #1;
    checkOutput("push_brk1", push_data, 8'hFF);
    push_brk = 1'b0; #1;
    checkOutput("push_brk0", push_data, 8'hEF);
    br_cond = 3'b000; #1; checkOutput("br_n_clear", {7'b0, br_taken}, 8'h00);
    br_cond = 3'b001; #1; checkOutput("br_n_set", {7'b0, br_taken}, 8'h01);
    br_cond = 3'b010; #1; checkOutput("br_v_clear", {7'b0, br_taken}, 8'h00);
    br_cond = 3'b100; #1; checkOutput("br_c_clear", {7'b0, br_taken}, 8'h00);
    br_cond = 3'b111; #1; checkOutput("br_z_set", {7'b0, br_taken}, 8'h01);

    // ALU path writes everything including B, bit5 still reads 1
    alu_wr = 1'b1; alu_status = 8'h03;
    tick();
    alu_wr = 1'b0;
    checkOutput("alu_write", status, 8'h23);
    br_cond = 3'b110; #1; checkOutput("br_z_clear", {7'b0, br_taken}, 8'h00);
    br_cond = 3'b101; #1; checkOutput("br_c_set", {7'b0, br_taken}, 8'h01);
    alu_wr = 1'b1; alu_status = 8'h10;
    tick();
    alu_wr = 1'b0;
    checkOutput("alu_b_write", status, 8'h30);
    checkOutput("push_irq_b0", push_data, 8'h20);
    plp_wr = 1'b1; plp_data = 8'h00;
    tick();
    plp_wr = 1'b0;
    checkOutput("plp_keeps_b", status, 8'h30);
    alu_wr = 1'b1; alu_status = 8'h00; int_ack = 1'b1;
    tick();
    alu_wr = 1'b0; int_ack = 1'b0;
    checkOutput("ack_sets_i", status, 8'h24);
    tick();

    // CLI with IRQ held low: first poll is masked only with the delay enabled
    irq_n = 1'b0;
    tick();
    alu_wr = 1'b1; alu_status = 8'h20;
    tick();
    alu_wr = 1'b0;
    checkOutput("cli_status", status, 8'h20);
    poll = 1'b1;
    tick();
    poll = 1'b0;
    checkOutput("cli_first_poll", {7'b0, int_pending}, DELAY_EN ? 8'h00 : 8'h01);
    poll = 1'b1;
    tick();
    poll = 1'b0;
    checkOutput("cli_second_poll", {7'b0, int_pending}, 8'h01);
    checkOutput("irq_src", {7'b0, int_nmi}, 8'h00);
    irq_n = 1'b1;
    tick();
    checkOutput("irq_drop_pend", {7'b0, int_pending}, 8'h01);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    checkOutput("irq_ack_clear", {7'b0, int_pending}, 8'h00);
    checkOutput("irq_ack_i", status, 8'h24);

    // NMI has priority over a simultaneous unmasked IRQ
    alu_wr = 1'b1; alu_status = 8'h20;
    tick();
    alu_wr = 1'b0;
    nmi_n = 1'b0; irq_n = 1'b0;
    tick();
    poll = 1'b1;
    tick();
    poll = 1'b0; nmi_n = 1'b1;
    checkOutput("nmi_pending", {7'b0, int_pending}, 8'h01);
    checkOutput("nmi_src", {7'b0, int_nmi}, 8'h01);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    checkOutput("nmi_ack_clear", {7'b0, int_pending}, 8'h00);
    checkOutput("nmi_ack_i", status, 8'h24);
    tick();
    poll = 1'b1;
    tick();
    poll = 1'b0;
    checkOutput("masked_after_nmi", {7'b0, int_pending}, 8'h00);

    // new NMI edge coinciding with the acknowledge survives
    nmi_n = 1'b0;
    tick();
    nmi_n = 1'b1;
    tick();
    poll = 1'b1;
    tick();
    poll = 1'b0;
    checkOutput("nmi2_pending", {7'b0, int_pending}, 8'h01);
    int_ack = 1'b1; nmi_n = 1'b0;
    tick();
    int_ack = 1'b0; nmi_n = 1'b1;
    checkOutput("nmi2_ack_clear", {7'b0, int_pending}, 8'h00);
    poll = 1'b1;
    tick();
    poll = 1'b0;
    checkOutput("nmi_edge_kept", {7'b0, int_pending}, 8'h01);
    checkOutput("nmi_edge_src", {7'b0, int_nmi}, 8'h01);

    // reset while pending with another NMI latched
    nmi_n = 1'b0; irq_n = 1'b1;
    tick();
    nmi_n = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("rst_pend_clear", {7'b0, int_pending}, 8'h00);
    checkOutput("rst_status", status, 8'h24);
    checkOutput("rst_int_nmi", {7'b0, int_nmi}, 8'h00);
    poll = 1'b1;
    tick();
    poll = 1'b0;
    checkOutput("rst_latch_gone", {7'b0, int_pending}, 8'h00);
    tick();

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
